iob_wb_master: RTL and testbench

IOB_WB_MASTER -- requirements
Module: iob_wb_master

---
 rtl/iob_wb_master.sv | 142 ++++++++++++++
 tb/tb_iob_wb_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_wb_master.sv
// rtl/iob_wb_master.sv - IOb slave to Wishbone classic master bridge
// One access in flight; optional ack timeout; sticky bus-error and timeout flags.
module iob_wb_master #(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 32,
  parameter int          WB_ADDR_W   = 10,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] TO_DATA     = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic [WB_ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0]    wb_sel_o,
  output logic                   wb_we_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic [DATA_W-1:0]      wb_dat_o,
  input  logic [DATA_W-1:0]      wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  output logic                   bus_err_o,
  output logic                   timeout_o,
  input  logic                   clr_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // Repeat the 32-bit timeout pattern across (or cut it down to) the data width.
  function automatic logic [DATA_W-1:0] to_fill();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = TO_DATA[i % 32];
    return r;
  endfunction

  localparam logic [DATA_W-1:0] TO_VAL = to_fill();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             ev_ack;
  logic             ev_err;
  logic             ev_to;
  logic             unused_addr;

  // Only the word-address slice of the byte address reaches the bus.
  assign unused_addr = ^address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ev_ack     = 1'b0;
    ev_err     = 1'b0;
    ev_to      = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid) begin
          accept     = 1'b1;
          state_next = S_BUS;
        end
      end
      S_BUS: begin
        // err beats ack; a response in the last allowed cycle beats the timeout
        if (wb_err_i) begin
          ev_err     = 1'b1;
          state_next = S_RESP;
        end else if (wb_ack_i) begin
          ev_ack     = 1'b1;
          state_next = S_RESP;
        end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
          ev_to      = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b0;
      rdata     <= '0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_dat_o  <= '0;
      wait_cnt  <= '0;
      bus_err_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      ready <= ev_ack | ev_err | ev_to;

      if (accept) begin
        wb_adr_o <= address[OFF_W +: WB_ADDR_W];
        wb_we_o  <= |wstrb;
        wb_sel_o <= (|wstrb) ? wstrb : {STRB_W{1'b1}};
        wb_dat_o <= wdata;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wait_cnt <= '0;
      end else if (state == S_BUS) begin
        if (ev_ack || ev_err || ev_to) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
        if (wait_cnt != {CNT_W{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      end

      if (ev_ack && !wb_we_o) rdata <= wb_dat_i;
      if (ev_err)             rdata <= '0;
      if (ev_to)              rdata <= TO_VAL;

      bus_err_o <= ev_err | (bus_err_o & ~clr_i);
      timeout_o <= ev_to  | (timeout_o & ~clr_i);
    end
  end

endmodule

// File: tb/tb_iob_wb_master.sv
// tb/tb_iob_wb_master.sv - scoreboard bench for iob_wb_master
module tb_iob_wb_master;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_SPUR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [9:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_err_o, timeout_o, clr_i;

  logic        nt_valid, nt_ready, nt_we, nt_cyc, nt_stb, nt_ack, nt_bus_err, nt_timeout;
  logic [31:0] nt_rdata, nt_dat_o, nt_dat_i;
  logic [9:0]  nt_adr;
  logic [3:0]  nt_sel;

  always #5 clk = ~clk;

  iob_wb_master #(
    .ADDR_W(16), .DATA_W(32), .WB_ADDR_W(10), .TIMEOUT_CYC(4), .TO_DATA(32'hDEADBEEF)
  ) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_err_o(bus_err_o), .timeout_o(timeout_o),
    .clr_i(clr_i)
  );

  iob_wb_master #(
    .ADDR_W(16), .DATA_W(32), .WB_ADDR_W(10), .TIMEOUT_CYC(0), .TO_DATA(32'hDEADBEEF)
  ) u_nt (
    .clk(clk), .rst(rst), .valid(nt_valid), .address(16'h0040), .wdata(32'h0), .wstrb(4'h0),
    .rdata(nt_rdata), .ready(nt_ready), .wb_adr_o(nt_adr), .wb_sel_o(nt_sel), .wb_we_o(nt_we),
    .wb_cyc_o(nt_cyc), .wb_stb_o(nt_stb), .wb_dat_o(nt_dat_o), .wb_dat_i(nt_dat_i),
    .wb_ack_i(nt_ack), .wb_err_i(1'b0), .bus_err_o(nt_bus_err), .timeout_o(nt_timeout),
    .clr_i(1'b0)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave model
  int          slave_mode  = M_NONE;
  int          slave_delay = 0;
  logic [31:0] slave_data  = '0;
  int          slave_wait  = 0;

  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (slave_mode == M_SPUR) begin
        if (!wb_cyc_o) begin
          wb_ack_i = 1'b1;
          wb_err_i = 1'b1;
          wb_dat_i = 32'h5555AAAA;
        end
      end else if (wb_cyc_o && wb_stb_o && slave_mode != M_NONE) begin
        if (slave_wait == slave_delay) begin
          wb_ack_i   = 1'b1;
          wb_err_i   = (slave_mode == M_ERR);
          wb_dat_i   = slave_data;
          slave_wait = 0;
        end else begin
          slave_wait++;
        end
      end else begin
        slave_wait = 0;
      end
    end
  end

  // Scoreboard: expected rdata per request, checked on each ready pulse
  logic [31:0] sb_q[$];
  int          ready_cnt  = 0;
  logic        prev_ready = 1'b0;

  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (ready) begin
        ready_cnt++;
        check_eq("ready_width", prev_ready, 1'b0);
        if (sb_q.size() == 0) begin
          check_eq("unexpected_ready", 1'b1, 1'b0);
        end else begin
          exp_rd = sb_q.pop_front();
          check_eq("rdata", rdata, exp_rd);
        end
      end
      prev_ready = ready;
    end
  end

  task automatic do_req(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rd, input int exp_lat, output int cyc_n);
    int n;
    logic [3:0] esel;
    @(negedge clk);
    sb_q.push_back(exp_rd);
    address = a;
    wdata   = wd;
    wstrb   = ws;
    valid   = 1'b1;
    esel    = (ws != 4'h0) ? ws : 4'hF;
    n       = 0;
    cyc_n   = 0;
    do begin
      @(negedge clk);
      n++;
      if (wb_cyc_o) cyc_n++;
      if (n == 1) begin
        check_eq("bus_stb", wb_stb_o, 1'b1);
        check_eq("bus_adr", wb_adr_o, a[11:2]);
        check_eq("bus_sel", wb_sel_o, esel);
        check_eq("bus_we", wb_we_o, |ws);
        if (ws != 4'h0) check_eq("bus_dat_o", wb_dat_o, wd);
      end
    end while (!ready && n < 60);
    check_eq("latency", n, exp_lat);
    valid = 1'b0;
  endtask

  initial begin
    int c;
    int snap;
    valid    = 1'b0;
    address  = '0;
    wdata    = '0;
    wstrb    = '0;
    clr_i    = 1'b0;
    nt_valid = 1'b0;
    nt_ack   = 1'b0;
    nt_dat_i = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_cyc", wb_cyc_o, 1'b0);
    check_eq("rst_stb", wb_stb_o, 1'b0);
    check_eq("rst_we", wb_we_o, 1'b0);
    check_eq("rst_adr", wb_adr_o, 10'h0);
    check_eq("rst_sel", wb_sel_o, 4'h0);
    check_eq("rst_dat_o", wb_dat_o, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_flags", {bus_err_o, timeout_o}, 2'b00);
    rst = 1'b0;

    // Read with ack three cycles after stb
    slave_mode = M_ACK; slave_delay = 3; slave_data = 32'hCAFEF00D;
    do_req(16'h0010, 32'h0, 4'h0, 32'hCAFEF00D, 5, c);
    check_eq("read_no_timeout", timeout_o, 1'b0);

    // Write with immediate ack leaves rdata alone
    slave_delay = 0; slave_data = 32'hFFFFFFFF;
    do_req(16'h0008, 32'h12345678, 4'h3, 32'hCAFEF00D, 2, c);

    // ack+err together: err wins, flag sticky until clr
    slave_mode = M_ERR; slave_delay = 1;
    do_req(16'h0020, 32'h0, 4'h0, 32'h0, 3, c);
    check_eq("err_set", bus_err_o, 1'b1);
    slave_mode = M_ACK; slave_delay = 0;
    do_req(16'h0024, 32'hA5A5A5A5, 4'hF, 32'h0, 2, c);
    check_eq("err_sticky", bus_err_o, 1'b1);
    @(negedge clk); clr_i = 1'b1;
    @(negedge clk); clr_i = 1'b0;
    check_eq("err_cleared", bus_err_o, 1'b0);
    clr_i = 1'b1; slave_mode = M_ERR;
    do_req(16'h0028, 32'h0, 4'h0, 32'h0, 2, c);
    check_eq("err_set_beats_clr", bus_err_o, 1'b1);
    @(negedge clk);
    clr_i = 1'b0;
    check_eq("err_clr_again", bus_err_o, 1'b0);

    // ack/err while idle must change nothing
    snap = ready_cnt;
    slave_mode = M_SPUR;
    repeat (5) @(negedge clk);
    check_eq("spur_ready", ready_cnt, snap);
    check_eq("spur_rdata", rdata, 32'h0);
    check_eq("spur_flags", {bus_err_o, timeout_o}, 2'b00);
    check_eq("spur_cyc", wb_cyc_o, 1'b0);

    // Timeout after four bus cycles
    slave_mode = M_NONE;
    do_req(16'h0040, 32'h0, 4'h0, 32'hDEADBEEF, 5, c);
    check_eq("to_cyc_cycles", c, 4);
    check_eq("to_flag", timeout_o, 1'b1);
    check_eq("to_no_err", bus_err_o, 1'b0);

    // Back-to-back reads
    snap = ready_cnt;
    slave_mode = M_ACK; slave_delay = 1; slave_data = 32'h11112222;
    do_req(16'h0100, 32'h0, 4'h0, 32'h11112222, 3, c);
    slave_delay = 0; slave_data = 32'h33334444;
    do_req(16'h0104, 32'h0, 4'h0, 32'h33334444, 2, c);
    @(negedge clk);
    check_eq("b2b_ready_pulses", ready_cnt - snap, 2);

    // Reset in the middle of a bus cycle
    slave_mode = M_NONE;
    snap = ready_cnt;
    @(negedge clk);
    address = 16'h0200; wstrb = 4'h0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check_eq("mid_bus_cyc", wb_cyc_o, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_bus_cyc", wb_cyc_o, 1'b0);
    check_eq("rst_bus_stb", wb_stb_o, 1'b0);
    check_eq("rst_bus_ready", ready, 1'b0);
    check_eq("rst_bus_flags", {bus_err_o, timeout_o}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_no_ready", ready_cnt, snap);
    slave_mode = M_ACK; slave_delay = 2; slave_data = 32'h0BADC0DE;
    do_req(16'h0204, 32'h0, 4'h0, 32'h0BADC0DE, 4, c);

    // TIMEOUT_CYC=0 instance waits for as long as it takes
    snap = 0;
    @(negedge clk); nt_valid = 1'b1;
    @(negedge clk); nt_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (nt_ready) snap++;
    end
    check_eq("nt_cyc_held", nt_cyc, 1'b1);
    check_eq("nt_no_ready", snap, 0);
    nt_ack = 1'b1; nt_dat_i = 32'h00000077;
    @(negedge clk);
    nt_ack = 1'b0;
    check_eq("nt_ready", nt_ready, 1'b1);
    check_eq("nt_rdata", nt_rdata, 32'h00000077);
    check_eq("nt_no_timeout", nt_timeout, 1'b0);

    @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
